// File: rtl/unary_add_pkg.sv
// unary_add_pkg: shared states, phase lengths and digit clamp for the unary BCD adder sequencer.
package unary_add_pkg;
   typedef enum logic [2:0] {IDLE, FLUSH, FDRAIN, READ, WRITE, DRAIN, DONE} state_t;
   localparam int DIGIT_MAX = 9;
   localparam int READ_LEN  = 10;
   localparam int WRITE_LEN = 9;
   localparam int FLUSH_LEN = 9;
   function automatic logic [3:0] clamp(input logic [3:0] d);
      return d > 4'(DIGIT_MAX) ? 4'(DIGIT_MAX) : d;
   endfunction
endpackage

// File: rtl/unary_pulse_cnt.sv
// unary_pulse_cnt: counts adder dout pulses while sampling is enabled, with synchronous clear.
module unary_pulse_cnt (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clr,
   input  logic       en,
   input  logic       pulse,
   output logic [3:0] cnt
);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt <= '0;
      else if (clr) cnt <= '0;
      else if (en && pulse) cnt <= cnt + 4'd1;
endmodule

// File: rtl/unary_bcd_add_ctrl.sv
// unary_bcd_add_ctrl: multi-digit BCD add, LSD first, by time-sharing one external mod-10 unary adder.
module unary_bcd_add_ctrl
   import unary_add_pkg::*;
#(
   parameter int NDIG = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [4*NDIG-1:0] a_bcd,
   input  logic [4*NDIG-1:0] b_bcd,
   input  logic              cin,
   output logic              busy,
   output logic              done,
   output logic [4*NDIG-1:0] sum_bcd,
   output logic              cout,
   output logic              bad_digit,
   output logic              ua_A,
   output logic              ua_B,
   output logic              ua_en,
   output logic              ua_rw,
   input  logic              ua_dout,
   input  logic              ua_C
);
   localparam int KW = NDIG > 1 ? $clog2(NDIG) : 1;
   state_t state, state_n;
   logic [3:0] ph, cnt;
   logic [KW-1:0] k;
   logic [NDIG-1:0][3:0] a_l, b_l, sum_q;
   logic [4:0] a_lim;
   logic cin_l, carry, carry_in, last, last_dig, bad_in;
   assign last = state == FLUSH ? ph == 4'(FLUSH_LEN - 1) :
                 state == READ  ? ph == 4'(READ_LEN - 1)  : ph == 4'(WRITE_LEN - 1);
   assign last_dig = k == KW'(NDIG - 1);
   // the incoming carry rides on the A train as one extra pulse
   assign a_lim = {1'b0, a_l[k]} + {4'b0, carry_in};
   assign busy = state != IDLE;
   assign done = state == DONE;
   assign ua_en = state inside {FLUSH, READ, WRITE};
   assign ua_rw = state inside {FLUSH, WRITE};
   assign ua_A = state == READ && {1'b0, ph} < a_lim;
   assign ua_B = state == READ && ph < b_l[k];
   assign sum_bcd = sum_q;
   always_comb begin
      bad_in = 1'b0;
      for (int i = 0; i < NDIG; i++)
         bad_in = bad_in | (a_bcd[4*i +: 4] > 4'(DIGIT_MAX)) | (b_bcd[4*i +: 4] > 4'(DIGIT_MAX));
   end
   always_comb begin
      state_n = state;
      unique case (state)
         IDLE:    state_n = start ? FLUSH : IDLE;
         FLUSH:   state_n = last ? FDRAIN : FLUSH;
         FDRAIN:  state_n = READ;
         READ:    state_n = last ? WRITE : READ;
         WRITE:   state_n = last ? DRAIN : WRITE;
         DRAIN:   state_n = last_dig ? DONE : READ;
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= IDLE;
         ph <= '0;
         k <= '0;
         a_l <= '0;
         b_l <= '0;
         sum_q <= '0;
         cin_l <= 1'b0;
         carry <= 1'b0;
         carry_in <= 1'b0;
         cout <= 1'b0;
         bad_digit <= 1'b0;
      end else begin
         state <= state_n;
         ph <= (state_n != state || !ua_en) ? 4'd0 : ph + 4'd1;
         if (state == IDLE && start) begin
            for (int i = 0; i < NDIG; i++) begin
               a_l[i] <= clamp(a_bcd[4*i +: 4]);
               b_l[i] <= clamp(b_bcd[4*i +: 4]);
            end
            cin_l <= cin;
            bad_digit <= bad_in;
         end
         if (state == FDRAIN) begin
            k <= '0;
            carry_in <= cin_l;
            carry <= 1'b0;
         end
         // ua_C is registered in the adder, so the wrap of the last READ cycle shows in WRITE w=0
         if ((state == READ && ph != 4'd0) || (state == WRITE && ph == 4'd0))
            carry <= carry | ua_C;
         if (state == DRAIN) begin
            sum_q[k] <= cnt + {3'b0, ua_dout};
            if (last_dig) cout <= carry;
            else begin
               k <= k + KW'(1);
               carry_in <= carry;
               carry <= 1'b0;
            end
         end
      end
   unary_pulse_cnt u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (state == DRAIN),
      .en    (state == WRITE && ph != 4'd0),
      .pulse (ua_dout),
      .cnt   (cnt)
   );
endmodule

// File: tb/tb_unary_bcd_add_ctrl.sv
// tb_unary_bcd_add_ctrl: directed vectors against unary_bcd_add_ctrl driving a behavioural mod-10 unary adder.
module tb_unary_bcd_add_ctrl;
   localparam int NDIG = 4;
   localparam int DONE_CYC = 11 + 20 * NDIG;
   typedef struct {
      logic [15:0] a, b;
      logic        cin;
      logic [15:0] sum;
      logic        cout, bad;
   } vec_t;
   logic clk = 0, rst_n = 1, start = 0, cin = 0;
   logic [15:0] a_bcd = 0, b_bcd = 0, sum_bcd;
   logic busy, done, cout, bad_digit, ua_A, ua_B, ua_en, ua_rw, ua_dout, ua_C;
   logic ovr = 0, o_a = 0;
   logic m_en, m_rw, m_a, m_b;
   logic [3:0] acc;
   logic [4:0] s;
   int n_chk = 0, n_fail = 0;
   always #5 clk = ~clk;
   unary_bcd_add_ctrl #(.NDIG(NDIG)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .a_bcd(a_bcd), .b_bcd(b_bcd), .cin(cin),
      .busy(busy), .done(done), .sum_bcd(sum_bcd), .cout(cout), .bad_digit(bad_digit),
      .ua_A(ua_A), .ua_B(ua_B), .ua_en(ua_en), .ua_rw(ua_rw), .ua_dout(ua_dout), .ua_C(ua_C)
   );
   // mod-10 unary adder: read phase accumulates A/B pulses, write phase emits the count as dout pulses
   assign m_en = ovr ? 1'b1 : ua_en;
   assign m_rw = ovr ? 1'b0 : ua_rw;
   assign m_a  = ovr ? o_a : ua_A;
   assign m_b  = ovr ? 1'b0 : ua_B;
   always @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         acc <= 0;
         ua_dout <= 0;
         ua_C <= 0;
      end else begin
         ua_dout <= 0;
         ua_C <= 0;
         s = {1'b0, acc} + {4'b0, m_a} + {4'b0, m_b};
         if (m_en && !m_rw) begin
            ua_C <= s >= 5'd10;
            acc <= s >= 5'd10 ? 4'(s - 5'd10) : s[3:0];
         end else if (m_en && m_rw && acc != 0) begin
            ua_dout <= 1;
            acc <= acc - 4'd1;
         end
      end
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask
   task automatic run(input logic [15:0] a, input logic [15:0] b, input logic ci, input int ign, input int rst_at,
                      output int dcyc, output int ndone, output int busy_bad, output int pa, output int pb, output int pab);
      dcyc = 0; ndone = 0; busy_bad = 0; pa = 0; pb = 0; pab = 0;
      @(negedge clk);
      a_bcd = a; b_bcd = b; cin = ci; start = 1;
      @(posedge clk);
      for (int c = 1; c <= DONE_CYC + 3; c++) begin
         @(negedge clk);
         start = c == ign;
         if (c == ign) begin a_bcd = 16'h9999; b_bcd = 16'h9999; cin = 1; end
         if (c == rst_at) begin
            #1 rst_n = 0;
            #1 return;
         end
         if (done) begin ndone++; if (dcyc == 0) dcyc = c; end
         if (busy !== (c <= DONE_CYC)) busy_bad++;
         if (c >= 11 && c <= 20) begin pa += int'(ua_A); pb += int'(ua_B); end
         pab += int'(ua_A) + int'(ua_B);
      end
      start = 0;
   endtask
   initial begin
      vec_t vecs[8];
      int dcyc, ndone, busy_bad, pa, pb, pab, ea;
      vecs[0] = '{16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0};
      vecs[1] = '{16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
      vecs[2] = '{16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1, 1'b0};
      vecs[3] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
      vecs[4] = '{16'h999C, 16'h0003, 1'b0, 16'h0002, 1'b1, 1'b1};
      vecs[5] = '{16'h0500, 16'h0500, 1'b1, 16'h1001, 1'b0, 1'b0};
      vecs[6] = '{16'h8000, 16'h2000, 1'b0, 16'h0000, 1'b1, 1'b0};
      vecs[7] = '{16'h00A0, 16'h0000, 1'b1, 16'h0091, 1'b0, 1'b1};
      #3 rst_n = 0;
      repeat (2) @(negedge clk);
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      chk("reset_sum", sum_bcd, 0);
      chk("reset_cout_bad", {cout, bad_digit}, 0);
      chk("reset_ua", {ua_A, ua_B, ua_en, ua_rw}, 0);
      rst_n = 1;
      for (int i = 0; i < 8; i++) begin
         run(vecs[i].a, vecs[i].b, vecs[i].cin, 0, 0, dcyc, ndone, busy_bad, pa, pb, pab);
         ea = (vecs[i].a[3:0] > 9 ? 9 : int'(vecs[i].a[3:0])) + int'(vecs[i].cin);
         chk($sformatf("v%0d_done_cycle", i), dcyc, DONE_CYC);
         chk($sformatf("v%0d_done_pulses", i), ndone, 1);
         chk($sformatf("v%0d_busy_wrong_cycles", i), busy_bad, 0);
         chk($sformatf("v%0d_sum", i), sum_bcd, vecs[i].sum);
         chk($sformatf("v%0d_cout", i), cout, vecs[i].cout);
         chk($sformatf("v%0d_bad_digit", i), bad_digit, vecs[i].bad);
         chk($sformatf("v%0d_d0_A_pulses", i), pa, ea);
         chk($sformatf("v%0d_d0_B_pulses", i), pb, int'(vecs[i].b[3:0]));
         if (vecs[i].a == 0 && vecs[i].b == 0 && !vecs[i].cin) chk("zero_ab_pulses", pab, 0);
      end
      run(16'h1234, 16'h5678, 1'b0, 30, 0, dcyc, ndone, busy_bad, pa, pb, pab);
      chk("ignored_start_done_cycle", dcyc, DONE_CYC);
      chk("ignored_start_done_pulses", ndone, 1);
      chk("ignored_start_sum", sum_bcd, 16'h6912);
      chk("ignored_start_cout", cout, 0);
      run(16'h2222, 16'h3333, 1'b0, 0, 40, dcyc, ndone, busy_bad, pa, pb, pab);
      chk("async_rst_busy_done", {busy, done}, 0);
      chk("async_rst_sum", sum_bcd, 0);
      chk("async_rst_cout_bad", {cout, bad_digit}, 0);
      chk("async_rst_ua", {ua_A, ua_B, ua_en, ua_rw}, 0);
      @(negedge clk);
      rst_n = 1;
      ovr = 1; o_a = 1;
      repeat (5) @(negedge clk);
      ovr = 0; o_a = 0;
      run(16'h0001, 16'h0002, 1'b0, 0, 0, dcyc, ndone, busy_bad, pa, pb, pab);
      chk("residue_done_cycle", dcyc, DONE_CYC);
      chk("residue_sum", sum_bcd, 16'h0003);
      chk("residue_cout", cout, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
